// File: rtl/icache_set_assoc_if.sv
// Fetch-side and memCtrl-side signal bundle for the instruction cache.
// The cache uses the slave view; the fetcher/memory environment uses master.
interface icache_set_assoc_if;
    logic        in_from_insFetcher_valid;
    logic [31:0] in_from_insFetcher_addr;
    logic        out_to_insFetcher_hit;
    logic [31:0] out_to_insFetcher_ins;
    logic        out_to_memCtrl_valid;
    logic [31:0] out_to_memCtrl_addr;
    logic        in_from_memCtrl_valid;
    logic [31:0] in_from_memCtrl_addr;
    logic [31:0] in_from_memCtrl_ins;

    modport slave (
        input  in_from_insFetcher_valid,
        input  in_from_insFetcher_addr,
        output out_to_insFetcher_hit,
        output out_to_insFetcher_ins,
        output out_to_memCtrl_valid,
        output out_to_memCtrl_addr,
        input  in_from_memCtrl_valid,
        input  in_from_memCtrl_addr,
        input  in_from_memCtrl_ins
    );

    modport master (
        output in_from_insFetcher_valid,
        output in_from_insFetcher_addr,
        input  out_to_insFetcher_hit,
        input  out_to_insFetcher_ins,
        input  out_to_memCtrl_valid,
        input  out_to_memCtrl_addr,
        output in_from_memCtrl_valid,
        output in_from_memCtrl_addr,
        output in_from_memCtrl_ins
    );
endinterface

// File: rtl/icache_set_assoc.sv
// Blocking set-associative instruction cache: combinational hit path,
// word-by-word line refill from memCtrl, round-robin replacement.
module icache_set_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              in_flush,
    icache_set_assoc_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic {IDLE, REFILL} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      base_q, base_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic             mreq_valid_q, mreq_valid_d;
    logic [31:0]      mreq_addr_q, mreq_addr_d;

    logic [SETS-1:0]  valid_q [WAYS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [31:0]      data_q  [WAYS][SETS][LINE_WORDS];
    logic [WAY_W-1:0] rr_q    [SETS];

    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] r_idx;
    logic [29:0]      f_word;
    logic [CNT_W-1:0] f_wsel;
    logic [31:0]      req_addr;
    logic [31:0]      hit_ins;
    logic             hit;
    logic             accept;
    logic [WAY_W-1:0] vic;
    logic             miss_clr;
    logic             fill_we;
    logic             line_done;
    logic             flush_all;

    assign f_tag    = bus.in_from_insFetcher_addr[31 -: TAG_W];
    assign f_idx    = bus.in_from_insFetcher_addr[OFF_W +: IDX_W];
    assign f_word   = bus.in_from_insFetcher_addr[31:2];
    assign f_wsel   = CNT_W'(f_word & 30'(LINE_WORDS - 1));
    assign r_idx    = base_q[OFF_W +: IDX_W];
    assign req_addr = base_q | (32'(cnt_q) << 2);

    // The fill rule guarantees at most one matching way, so OR-ing is safe.
    always_comb begin
        hit_ins = '0;
        hit     = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][f_idx] && tag_q[w][f_idx] == f_tag) begin
                hit     = 1'b1;
                hit_ins = hit_ins | data_q[w][f_idx][f_wsel];
            end
        end
        hit = hit && state_q == IDLE && bus.in_from_insFetcher_valid;
    end

    always_comb begin
        vic = rr_q[f_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][f_idx]) vic = WAY_W'(w);
        end
    end

    assign accept = state_q == REFILL &&
                    bus.in_from_memCtrl_valid &&
                    bus.in_from_memCtrl_addr == req_addr;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        victim_d     = victim_q;
        mreq_valid_d = mreq_valid_q;
        mreq_addr_d  = mreq_addr_q;
        miss_clr     = 1'b0;
        fill_we      = 1'b0;
        line_done    = 1'b0;
        flush_all    = 1'b0;
        if (!rdy) begin
            state_d = state_q;
        end else if (in_flush) begin
            flush_all    = 1'b1;
            state_d      = IDLE;
            mreq_valid_d = 1'b0;
        end else if (clr) begin
            state_d      = IDLE;
            mreq_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_from_insFetcher_valid && !hit) begin
                        base_d       = {f_tag, f_idx, {OFF_W{1'b0}}};
                        victim_d     = vic;
                        miss_clr     = 1'b1;
                        cnt_d        = '0;
                        state_d      = REFILL;
                        mreq_valid_d = 1'b1;
                        mreq_addr_d  = {f_tag, f_idx, {OFF_W{1'b0}}};
                    end
                end
                REFILL: begin
                    if (accept) begin
                        fill_we = 1'b1;
                        if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
                            line_done    = 1'b1;
                            state_d      = IDLE;
                            mreq_valid_d = 1'b0;
                        end else begin
                            cnt_d       = cnt_q + CNT_W'(1);
                            mreq_addr_d = req_addr + 32'd4;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            base_q       <= '0;
            victim_q     <= '0;
            mreq_valid_q <= 1'b0;
            mreq_addr_q  <= '0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            victim_q     <= victim_d;
            mreq_valid_q <= mreq_valid_d;
            mreq_addr_q  <= mreq_addr_d;
            if (flush_all) begin
                for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            end
            if (miss_clr) valid_q[vic][f_idx] <= 1'b0;
            if (line_done) begin
                tag_q[victim_q][r_idx]   <= base_q[31 -: TAG_W];
                valid_q[victim_q][r_idx] <= 1'b1;
                rr_q[r_idx] <= (victim_q == WAY_W'(WAYS - 1)) ?
                               '0 : victim_q + WAY_W'(1);
            end
        end
    end

    // Line storage carries no reset; valid bits gate every read.
    always_ff @(posedge clk) begin
        if (!rst && fill_we) begin
            data_q[victim_q][r_idx][cnt_q] <= bus.in_from_memCtrl_ins;
        end
    end

    assign bus.out_to_insFetcher_hit = hit;
    assign bus.out_to_insFetcher_ins = hit ? hit_ins : 32'd0;
    assign bus.out_to_memCtrl_valid  = mreq_valid_q;
    assign bus.out_to_memCtrl_addr   = mreq_addr_q;
endmodule

// File: tb/tb_icache_set_assoc.sv
// Scoreboard bench for icache_set_assoc: expected memCtrl requests and hit
// words are queued by the stimulus and popped by a negedge monitor.
module tb_icache_set_assoc;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst, rdy, clr, in_flush;

    icache_set_assoc_if bus ();

    icache_set_assoc #(.WAYS(2), .SETS(64), .LINE_WORDS(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .clr      (clr),
        .in_flush (in_flush),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] req_q [$];
    logic [31:0] hit_q [$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Monitor: a new request is valid rising or the address moving while
    // valid; a new hit is hit rising or the fetch address moving while hit.
    logic        pv = 1'b0;
    logic        ph = 1'b0;
    logic [31:0] pa = '0;
    logic [31:0] pfa = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_to_memCtrl_valid &&
                (!pv || bus.out_to_memCtrl_addr != pa)) begin
                if (req_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL req_unexpected got=%h exp=none",
                             bus.out_to_memCtrl_addr);
                end else begin
                    chk("req_addr", bus.out_to_memCtrl_addr, req_q.pop_front());
                end
            end
            if (bus.out_to_insFetcher_hit &&
                (!ph || bus.in_from_insFetcher_addr != pfa)) begin
                if (hit_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL hit_unexpected got=%h exp=none",
                             bus.out_to_insFetcher_ins);
                end else begin
                    chk("hit_ins", bus.out_to_insFetcher_ins, hit_q.pop_front());
                end
            end
        end
        pv  = bus.out_to_memCtrl_valid;
        pa  = bus.out_to_memCtrl_addr;
        ph  = bus.out_to_insFetcher_hit;
        pfa = bus.in_from_insFetcher_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve_words(input int n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!bus.out_to_memCtrl_valid && w < 20) begin
                tick();
                w++;
            end
            if (!bus.out_to_memCtrl_valid) begin
                total++;
                bad++;
                $display("FAIL serve_timeout got=0 exp=1");
                return;
            end
            bus.in_from_memCtrl_valid = 1'b1;
            bus.in_from_memCtrl_addr  = bus.out_to_memCtrl_addr;
            bus.in_from_memCtrl_ins   = word_of(bus.out_to_memCtrl_addr);
            tick();
            bus.in_from_memCtrl_valid = 1'b0;
        end
    endtask

    task automatic expect_line(input logic [31:0] a);
        for (int i = 0; i < LW; i++) req_q.push_back(a + 32'(4 * i));
    endtask

    task automatic fill(input logic [31:0] a);
        expect_line(a);
        hit_q.push_back(word_of(a));
        bus.in_from_insFetcher_valid = 1'b1;
        bus.in_from_insFetcher_addr  = a;
        @(negedge clk);
        chk("miss_hit0", 32'(bus.out_to_insFetcher_hit), 32'd0);
        tick();
        serve_words(LW);
        tick();
        bus.in_from_insFetcher_valid = 1'b0;
        tick();
    endtask

    task automatic probe(input logic [31:0] a);
        hit_q.push_back(word_of(a));
        bus.in_from_insFetcher_valid = 1'b1;
        bus.in_from_insFetcher_addr  = a;
        @(negedge clk);
        chk("probe_hit", 32'(bus.out_to_insFetcher_hit), 32'd1);
        tick();
        bus.in_from_insFetcher_valid = 1'b0;
        @(negedge clk);
        chk("probe_noreq", 32'(bus.out_to_memCtrl_valid), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        clr = 1'b0;
        in_flush = 1'b0;
        bus.in_from_insFetcher_valid = 1'b0;
        bus.in_from_insFetcher_addr  = '0;
        bus.in_from_memCtrl_valid    = 1'b0;
        bus.in_from_memCtrl_addr     = '0;
        bus.in_from_memCtrl_ins      = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hit", 32'(bus.out_to_insFetcher_hit), 32'd0);
        chk("rst_ins", bus.out_to_insFetcher_ins, 32'd0);
        chk("rst_mvalid", 32'(bus.out_to_memCtrl_valid), 32'd0);
        chk("rst_maddr", bus.out_to_memCtrl_addr, 32'd0);
        tick();

        // cold miss and refill, then same-line hit
        fill(32'h0000_1000);
        probe(32'h0000_100C);

        // three lines in set 0 of a 2-way cache
        fill(32'h0000_2000);
        fill(32'h0000_3000);
        probe(32'h0000_2000);
        fill(32'h0000_1000);

        // clr after two words, then a stale response
        req_q.push_back(32'h0000_4000);
        req_q.push_back(32'h0000_4004);
        req_q.push_back(32'h0000_4008);
        bus.in_from_insFetcher_valid = 1'b1;
        bus.in_from_insFetcher_addr  = 32'h0000_4000;
        tick();
        serve_words(2);
        clr = 1'b1;
        bus.in_from_insFetcher_valid = 1'b0;
        tick();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_mvalid", 32'(bus.out_to_memCtrl_valid), 32'd0);
        tick();
        bus.in_from_memCtrl_valid = 1'b1;
        bus.in_from_memCtrl_addr  = 32'h0000_4008;
        bus.in_from_memCtrl_ins   = word_of(32'h0000_4008);
        tick();
        bus.in_from_memCtrl_valid = 1'b0;
        @(negedge clk);
        chk("stale_mvalid", 32'(bus.out_to_memCtrl_valid), 32'd0);
        tick();
        fill(32'h0000_4000);

        // flush drops every cached line
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        tick();
        fill(32'h0000_4000);
        fill(32'h0000_1000);

        // blocking refill with a rdy stall and an ignored response
        expect_line(32'h0000_5000);
        hit_q.push_back(word_of(32'h0000_5000));
        bus.in_from_insFetcher_valid = 1'b1;
        bus.in_from_insFetcher_addr  = 32'h0000_5000;
        tick();
        serve_words(1);
        bus.in_from_insFetcher_addr = 32'h0000_1000;
        @(negedge clk);
        chk("refill_blocks_hit", 32'(bus.out_to_insFetcher_hit), 32'd0);
        tick();
        bus.in_from_insFetcher_addr = 32'h0000_5000;
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.in_from_memCtrl_valid = (c == 1);
            bus.in_from_memCtrl_addr  = 32'h0000_5004;
            bus.in_from_memCtrl_ins   = word_of(32'h0000_5004);
            @(negedge clk);
            chk("stall_mvalid", 32'(bus.out_to_memCtrl_valid), 32'd1);
            chk("stall_maddr", bus.out_to_memCtrl_addr, 32'h0000_5004);
            tick();
        end
        bus.in_from_memCtrl_valid = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        chk("resume_maddr", bus.out_to_memCtrl_addr, 32'h0000_5004);
        tick();
        serve_words(LW - 1);
        tick();
        bus.in_from_insFetcher_valid = 1'b0;
        repeat (3) tick();

        chk("req_left", 32'(req_q.size()), 32'd0);
        chk("hit_left", 32'(hit_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
